// File: rtl/puck_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM state encoding
// and the default FIFO depth.
package puck_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    WAIT = 2'd3
  } tx_state_t;

endpackage

// File: rtl/txfifo_mem.sv
// Byte storage for the UART transmit FIFO: register array with one
// synchronous write port and one combinational read port. Not reset.
module txfifo_mem
  import puck_pkg::*;
#(
  parameter int unsigned ADDR_W = DEPTH_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**ADDR_W];

  // Write port: store the pushed byte at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_txfifo.sv
// UART transmit FIFO: buffers bytes from the monitor/cpu mux and feeds them
// one at a time to the UART, waiting for the UART busy flag between bytes.
// Optional sticky overflow flag enabled by defining UART_TXFIFO_OVF_EN.
module uart_txfifo
  import puck_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic [7:0]          tx_byte,
  output logic                transmit,
  input  logic                is_transmitting,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam logic [DEPTH_LOG2:0]   LP_CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LP_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  tx_state_t             r_state;
  logic [7:0]            r_tx_byte;
  logic                  r_transmit;

  logic                  w_push;
  logic                  w_pop;
  tx_state_t             w_state_nxt;
  logic [7:0]            w_rd_data;

  assign full     = (r_count == LP_CNT_FULL);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign tx_byte  = r_tx_byte;
  assign transmit = r_transmit;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_push = wr_en && !full;

  txfifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LP_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + LP_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM next-state: pop in IDLE, one-cycle SEND and GAP, then WAIT
  // until the UART reports idle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && !is_transmitting) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND:    w_state_nxt = GAP;
      GAP:     w_state_nxt = WAIT;
      WAIT:    if (!is_transmitting) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Drain FSM registers: the popped byte is latched together with the
  // transmit strobe so both become visible on entry to SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_byte  <= '0;
      r_transmit <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_transmit <= (w_state_nxt == SEND);
      if (w_pop) r_tx_byte <= w_rd_data;
    end
  end

`ifdef UART_TXFIFO_OVF_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop = wr_en && full;

  // Sticky overflow: a drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = ovf_clr;
  assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txfifo.sv
// Self-checking bench for uart_txfifo (DEPTH_LOG2=2) with a behavioural
// UART busy model and a byte-order scoreboard.
module tb_uart_txfifo;

  localparam int unsigned DL2       = 2;
  localparam int unsigned UART_BUSY = 10;
`ifdef UART_TXFIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         full;
  logic         empty;
  logic [DL2:0] count;
  logic [7:0]   tx_byte;
  logic         transmit;
  logic         is_transmitting;
  logic         overflow;
  logic         ovf_clr;
  logic         hold_busy;

  int unsigned  busy_cnt = 0;
  int           checks = 0;
  int           errors = 0;
  int           busy_viol = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   obs_q[$];

  uart_txfifo #(
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting),
    .overflow        (overflow),
    .ovf_clr         (ovf_clr)
  );

  always #5 clk = ~clk;

  // UART model: busy for UART_BUSY cycles after each transmit strobe.
  always @(posedge clk) begin
    if (transmit) busy_cnt <= UART_BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign is_transmitting = hold_busy || (busy_cnt != 0);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock, sample just after the edge, record transmitted bytes.
  task automatic step();
    @(posedge clk);
    #1;
    if (transmit) begin
      obs_q.push_back(tx_byte);
      if (is_transmitting) busy_viol++;
    end
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit timed_out);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < bound) begin
      step();
      n++;
      if (empty && !is_transmitting && !transmit) quiet++;
      else quiet = 0;
    end
    timed_out = (quiet < 3);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0; hold_busy = 1'b0;
    #2;
    checks++; if (count !== 3'd0)   begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL rst_empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL rst_full: got %b exp 0", full); end
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL rst_transmit: got %b exp 0", transmit); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx_byte: got %h exp 00", tx_byte); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit to;
    logic [7:0] e, o;
    push(8'h41, 1'b1);
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL single_n1_tx: got %b exp 0", transmit); end
    checks++; if (count !== 3'd1)    begin errors++; $display("FAIL single_n1_count: got %0d exp 1", count); end
    step();
    checks++; if (transmit !== 1'b1) begin errors++; $display("FAIL single_n2_tx: got %b exp 1", transmit); end
    checks++; if (tx_byte !== 8'h41) begin errors++; $display("FAIL single_n2_byte: got %h exp 41", tx_byte); end
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL single_n2_count: got %0d exp 0", count); end
    step();
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL single_n3_tx: got %b exp 0", transmit); end
    checks++; if (tx_byte !== 8'h41) begin errors++; $display("FAIL single_hold_byte: got %h exp 41", tx_byte); end
    wait_idle(100, to);
    checks++; if (to) begin errors++; $display("FAIL single_idle: got timeout exp idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_order: got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL single_order: got %h exp %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra: got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_burst();
    bit to;
    logic [7:0] e, o;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    wait_idle(300, to);
    checks++; if (to) begin errors++; $display("FAIL burst_idle: got timeout exp idle"); end
    checks++; if (busy_viol != 0) begin errors++; $display("FAIL burst_busy: got %0d transmits while busy exp 0", busy_viol); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL burst_order: got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL burst_order: got %h exp %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL burst_extra: got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  // Leaves the FIFO full with the UART held busy for test_ovf_clr.
  task automatic test_full_drop();
    logic [DL2:0] c_exp;
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(8'(8'hA0 + i), i < 4);
      c_exp = (i < 4) ? 3'(i + 1) : 3'd4;
      checks++; if (count !== c_exp) begin errors++; $display("FAIL full_count%0d: got %0d exp %0d", i, count, c_exp); end
      checks++; if (full !== (i >= 3)) begin errors++; $display("FAIL full_flag%0d: got %b exp %b", i, full, i >= 3); end
    end
    checks++; if (overflow !== OVF_EXP) begin errors++; $display("FAIL full_overflow: got %b exp %b", overflow, OVF_EXP); end
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL full_no_tx: got %b exp 0", transmit); end
  endtask

  task automatic test_ovf_clr();
    bit to;
    logic [7:0] e, o;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
    ovf_clr = 1'b1;
    push(8'hEE, 1'b0);
    ovf_clr = 1'b0;
    checks++; if (overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_clr_vs_drop: got %b exp %b", overflow, OVF_EXP); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", count); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    hold_busy = 1'b0;
    wait_idle(300, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_idle: got timeout exp idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL full_order: got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL full_order: got %h exp %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL full_extra: got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_wrap();
    bit to;
    int n;
    logic [7:0] e, o;
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(8'(8'h10 + i), 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL wrap_pre_count: got %0d exp 3", count); end
    hold_busy = 1'b0;
    push(8'h13, 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL wrap_push_pop_count: got %0d exp 3", count); end
    for (int i = 4; i < 20; i++) begin
      n = 0;
      while (count == 3'd4 && n < 100) begin step(); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL wrap_space%0d: got timeout exp space", i); end
      push(8'(8'h10 + i), 1'b1);
    end
    wait_idle(400, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_idle: got timeout exp idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_order: got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wrap_order: got %h exp %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra: got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [7:0] e, o;
    // First byte is sent; the two behind it are aborted by the reset.
    push(8'h55, 1'b1);
    push(8'h66, 1'b0);
    push(8'h77, 1'b0);
    step();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d exp 2", count); end
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL rstmid_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rstmid_empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rstmid_full: got %b exp 0", full); end
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL rstmid_tx: got %b exp 0", transmit); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h exp 00", tx_byte); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b exp 0", overflow); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    push(8'h99, 1'b1);
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_idle: got timeout exp idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_order: got none exp %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rstmid_order: got %h exp %h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_extra: got %0d exp 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_drop();
    test_ovf_clr();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txfifo.md
UART_TXFIFO -- requirements
Module: uart_txfifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO holds 2**DEPTH_LOG2 bytes (legal 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  one-cycle push strobe from monitor/cpu mux (replaces direct uart transmit).
REQ-005 SHALL have port wr_data  input  8  byte pushed when wr_en high.
REQ-006 SHALL have port full  output  1  high when count == 2**DEPTH_LOG2.
REQ-007 SHALL have port empty  output  1  high when count == 0.
REQ-008 SHALL have port count  output  DEPTH_LOG2+1  bytes currently stored.
REQ-009 SHALL have port tx_byte  output  8  byte presented to uart tx_byte.
REQ-010 SHALL have port transmit  output  1  registered one-cycle strobe to uart transmit.
REQ-011 SHALL have port is_transmitting  input  1  uart busy flag.
REQ-012 SHALL have port overflow  output  1  sticky dropped-write flag.
REQ-013 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-014 SHALL accept a push when wr_en && !full: store wr_data at write pointer, increment pointer modulo depth.
REQ-015 SHALL drop a push when wr_en && full, leaving storage, pointers and count unchanged, regardless of a same-cycle pop.
REQ-016 SHALL implement drain FSM states IDLE, SEND, GAP, WAIT.
REQ-017 SHALL, in IDLE with !empty && !is_transmitting, load tx_byte from read pointer, pulse transmit next cycle, pop entry, and go to SEND.
REQ-018 SHALL leave SEND after exactly one cycle (transmit high only in SEND) to GAP.
REQ-019 SHALL spend exactly one cycle in GAP, ignoring is_transmitting, then go to WAIT.
REQ-020 SHALL stay in WAIT while is_transmitting is high and return to IDLE when it is low.
REQ-021 SHALL give latency: push at cycle N into empty FIFO with FSM IDLE and uart idle -> transmit high at cycle N+2, tx_byte valid same cycle and held until next SEND.
REQ-022 SHALL, on simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-023 SHALL wrap read and write pointers from 2**DEPTH_LOG2-1 to 0; count never exceeds depth or underflows.
REQ-024 SHALL never pop when empty; IDLE waits.
REQ-025 SHALL preserve byte order exactly (FIFO).

Reset
REQ-026 SHALL, on rst high, immediately clear pointers, count=0, empty=1, full=0, transmit=0, tx_byte=8'h00, overflow=0, FSM=IDLE; storage contents undefined.
REQ-027 SHALL abort any in-progress drain on reset mid-operation; the uart byte already started is not retracted.

Configuration
REQ-028 SHALL, with UART_TXFIFO_OVF_EN defined, set overflow on any dropped push and hold it until ovf_clr; ovf_clr and a drop in the same cycle leave overflow=1.
REQ-029 SHALL, without UART_TXFIFO_OVF_EN, tie overflow to 0 and ignore ovf_clr; drop behaviour unchanged.

Structure
REQ-030 SHALL take FSM state encodings (2-bit IDLE=0, SEND=1, GAP=2, WAIT=3) and default DEPTH_LOG2 from the shared package puck_pkg.
REQ-031 SHALL place storage in sub-module txfifo_mem: register array, one write port, combinational read port; pointer/count/FSM logic stays in uart_txfifo.

Verification
REQ-032 SHALL cover: reset, push 8'h41 with uart idle -> transmit pulse at N+2 with tx_byte=8'h41, count back to 0.
REQ-033 SHALL cover: burst push 8'h01..8'h05 back-to-back, model uart busy 10 cycles per byte -> five transmits in order 01..05, each only after is_transmitting low.
REQ-034 SHALL cover: DEPTH_LOG2=2, hold is_transmitting high, push 6 bytes -> full=1 after 4 stored, count=4, bytes 5-6 dropped, overflow=1 (macro on) / 0 (macro off).
REQ-035 SHALL cover: push while pop in same cycle at count=3 -> count stays 3, order preserved across pointer wrap after 20 bytes.
REQ-036 SHALL cover: assert rst during WAIT with count=2 -> all outputs at reset values same cycle, no further transmit until new push.
REQ-037 SHALL cover: overflow set, then ovf_clr pulse -> overflow=0 next cycle; ovf_clr coinciding with a drop -> overflow stays 1.
